// File: rtl/softreg_req_bridge.sv
// Soft-register request bridge.
// Queues shell soft-register reads/writes in a request FIFO and issues them downstream with
// valid/ready. Read responses come back in order; a read that waits too long is completed with
// filler data so host reads never hang, and its late response is discarded.
//
// Ports:
//   clk, rst                     single clock, synchronous active-high reset
//   softreg_read_in/write_in     one-cycle request strobes from the shell
//   softreg_addr_in/wrdata_in    request address / write data
//   softreg_rddata_out/rdvalid_out  read data back to the shell (one-cycle valid pulse)
//   req_valid/req_ready          downstream request handshake
//   req_is_write/addr/data       downstream request fields (data is 0 for reads)
//   resp_valid/resp_data         downstream read response (no backpressure)
//   ovf_count                    saturating count of requests dropped on a full FIFO
//   err_flags                    sticky {spurious_resp, rd_wr_collision, timeout_seen}
module softreg_req_bridge #(
  parameter int unsigned FIFO_LOG_DEPTH = 4,
  parameter int unsigned MAX_RD_OUT     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [63:0] TIMEOUT_DATA   = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        softreg_read_in,
  input  logic        softreg_write_in,
  input  logic [31:0] softreg_addr_in,
  input  logic [63:0] softreg_wrdata_in,
  output logic [63:0] softreg_rddata_out,
  output logic        softreg_rdvalid_out,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_is_write,
  output logic [31:0] req_addr,
  output logic [63:0] req_data,
  input  logic        resp_valid,
  input  logic [63:0] resp_data,
  output logic [15:0] ovf_count,
  output logic [2:0]  err_flags
);

  localparam int unsigned Depth = 1 << FIFO_LOG_DEPTH;
  localparam int unsigned RdW   = $clog2(MAX_RD_OUT + 1);
  localparam int unsigned TmW   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [FIFO_LOG_DEPTH:0] DepthC = (FIFO_LOG_DEPTH + 1)'(Depth);
  localparam logic [RdW-1:0]          MaxRd  = RdW'(MAX_RD_OUT);
  localparam logic [TmW-1:0]          TmLast = TmW'(TIMEOUT_CYCLES - 1);

  typedef struct packed {
    logic        is_write;
    logic [31:0] addr;
    logic [63:0] data;
  } req_t;

  req_t                      mem_q [Depth];
  logic [FIFO_LOG_DEPTH-1:0] wr_idx_q, rd_idx_q;
  logic [FIFO_LOG_DEPTH:0]   count_q, count_d;
  logic [RdW-1:0]            rd_out_q, rd_out_d;
  logic [RdW-1:0]            drop_pend_q, drop_pend_d;
  logic [TmW-1:0]            timer_q, timer_d;
  logic [15:0]               ovf_q, ovf_d;
  logic [2:0]                err_q, err_d;
  logic                      rdvalid_q, rdvalid_d;
  logic [63:0]               rddata_q, rddata_d;

  req_t head, enq_entry;
  logic empty, full, deq, rd_xfer, enq_req, enq;
  logic drop_resp, fwd, spurious, timeout, complete;

  always_comb begin
    head      = mem_q[rd_idx_q];
    empty     = (count_q == '0);
    full      = (count_q == DepthC);
    // Reads are held at the head once MAX_RD_OUT are outstanding; writes always proceed.
    req_valid = !empty && (head.is_write || (rd_out_q < MaxRd));
    deq       = req_valid && req_ready;
    rd_xfer   = deq && !head.is_write;

    enq_req = softreg_read_in || softreg_write_in;
    // A same-cycle dequeue frees a slot before the enqueue is considered.
    enq     = enq_req && (!full || deq);
    // On a read/write collision the write wins.
    enq_entry.is_write = softreg_write_in;
    enq_entry.addr     = softreg_addr_in;
    enq_entry.data     = softreg_write_in ? softreg_wrdata_in : 64'h0;

    drop_resp = resp_valid && (drop_pend_q != '0);
    fwd       = resp_valid && !drop_resp && (rd_out_q != '0);
    spurious  = resp_valid && !drop_resp && (rd_out_q == '0);
    // A forwarded response in the timeout cycle beats the filler.
    timeout   = (rd_out_q != '0) && (timer_q == TmLast) && !fwd;
    complete  = fwd || timeout;
  end

  always_comb begin
    count_d = count_q;
    unique case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    rd_out_d = rd_out_q;
    unique case ({rd_xfer, complete})
      2'b10:   rd_out_d = rd_out_q + RdW'(1);
      2'b01:   rd_out_d = rd_out_q - RdW'(1);
      default: rd_out_d = rd_out_q;
    endcase

    drop_pend_d = drop_pend_q;
    if (drop_resp && !timeout) begin
      drop_pend_d = drop_pend_q - RdW'(1);
    end else if (timeout && !drop_resp && (drop_pend_q != MaxRd)) begin
      drop_pend_d = drop_pend_q + RdW'(1);
    end

    timer_d = ((rd_out_q == '0) || complete) ? '0 : timer_q + TmW'(1);

    ovf_d = ovf_q;
    if (enq_req && !enq && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end

    err_d = err_q | {spurious, softreg_read_in && softreg_write_in, timeout};

    rdvalid_d = complete;
    rddata_d  = rddata_q;
    if (fwd) begin
      rddata_d = resp_data;
    end else if (timeout) begin
      rddata_d = TIMEOUT_DATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      count_q     <= '0;
      rd_out_q    <= '0;
      drop_pend_q <= '0;
      timer_q     <= '0;
      ovf_q       <= '0;
      err_q       <= '0;
      rdvalid_q   <= 1'b0;
      rddata_q    <= '0;
    end else begin
      if (enq) wr_idx_q <= wr_idx_q + 1'b1;
      if (deq) rd_idx_q <= rd_idx_q + 1'b1;
      count_q     <= count_d;
      rd_out_q    <= rd_out_d;
      drop_pend_q <= drop_pend_d;
      timer_q     <= timer_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      rdvalid_q   <= rdvalid_d;
      rddata_q    <= rddata_d;
    end
  end

  // Storage needs no reset: the occupancy count gates every use of it.
  always_ff @(posedge clk) begin
    if (enq && !rst) mem_q[wr_idx_q] <= enq_entry;
  end

  // Fields read as zero when nothing is queued so outputs are 0 out of reset.
  assign req_is_write        = !empty && head.is_write;
  assign req_addr            = empty ? 32'h0 : head.addr;
  assign req_data            = empty ? 64'h0 : head.data;
  assign softreg_rdvalid_out = rdvalid_q;
  assign softreg_rddata_out  = rddata_q;
  assign ovf_count           = ovf_q;
  assign err_flags           = err_q;

endmodule

// File: tb/tb_softreg_req_bridge.sv
module tb_softreg_req_bridge;

  localparam int unsigned LD    = 4;
  localparam int unsigned MRO   = 4;
  localparam int unsigned TO    = 64;
  localparam int          DEPTH = 16;
  localparam logic [63:0] TD    = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        softreg_read_in, softreg_write_in;
  logic [31:0] softreg_addr_in;
  logic [63:0] softreg_wrdata_in;
  logic [63:0] softreg_rddata_out;
  logic        softreg_rdvalid_out;
  logic        req_valid, req_ready, req_is_write;
  logic [31:0] req_addr;
  logic [63:0] req_data;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic [15:0] ovf_count;
  logic [2:0]  err_flags;

  always #5 clk = ~clk;

  softreg_req_bridge #(
    .FIFO_LOG_DEPTH(LD),
    .MAX_RD_OUT    (MRO),
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_DATA  (TD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .softreg_read_in    (softreg_read_in),
    .softreg_write_in   (softreg_write_in),
    .softreg_addr_in    (softreg_addr_in),
    .softreg_wrdata_in  (softreg_wrdata_in),
    .softreg_rddata_out (softreg_rddata_out),
    .softreg_rdvalid_out(softreg_rdvalid_out),
    .req_valid          (req_valid),
    .req_ready          (req_ready),
    .req_is_write       (req_is_write),
    .req_addr           (req_addr),
    .req_data           (req_data),
    .resp_valid         (resp_valid),
    .resp_data          (resp_data),
    .ovf_count          (ovf_count),
    .err_flags          (err_flags)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: request queue plus counters, advanced once per clock.
  bit [96:0] mq[$];
  int        m_rd_out, m_dp, m_timer, m_ovf;
  bit [2:0]  m_err;
  bit        m_rdv;
  bit [63:0] m_rdd;

  // Stimulus for the next clock.
  bit        s_rst, s_rd, s_wr, s_ready, s_rv;
  bit [31:0] s_addr;
  bit [63:0] s_wd, s_rdat;

  function automatic bit exp_valid();
    return (mq.size() > 0) && (mq[0][96] || (m_rd_out < MRO));
  endfunction

  task automatic model_step();
    bit v, deq, isrd, drop, fwd, spur, to;
    bit [96:0] ent;
    if (s_rst) begin
      mq.delete();
      m_rd_out = 0; m_dp = 0; m_timer = 0; m_ovf = 0;
      m_err = '0; m_rdv = 0; m_rdd = '0;
      return;
    end
    v    = exp_valid();
    deq  = v && s_ready;
    isrd = deq && !mq[0][96];
    drop = s_rv && (m_dp > 0);
    fwd  = s_rv && !drop && (m_rd_out > 0);
    spur = s_rv && !drop && (m_rd_out == 0);
    to   = (m_rd_out > 0) && (m_timer == TO - 1) && !fwd;
    if (deq) void'(mq.pop_front());
    if (s_rd || s_wr) begin
      ent = s_wr ? {1'b1, s_addr, s_wd} : {1'b0, s_addr, 64'h0};
      if (mq.size() < DEPTH) mq.push_back(ent);
      else if (m_ovf < 16'hFFFF) m_ovf++;
    end
    m_timer  = (m_rd_out == 0 || fwd || to) ? 0 : m_timer + 1;
    m_rd_out = m_rd_out + int'(isrd) - int'(fwd || to);
    m_dp     = m_dp - int'(drop) + int'(to);
    if (m_dp > MRO) m_dp = MRO;
    m_rdv = fwd || to;
    if (fwd) m_rdd = s_rdat;
    else if (to) m_rdd = TD;
    m_err |= {spur, s_rd && s_wr, to};
  endtask

  // Check outputs at the falling edge, then apply this cycle's stimulus.
  task automatic cycle();
    bit v;
    @(negedge clk);
    v = exp_valid();
    check("req_valid", req_valid, v);
    if (v) check("req_fields", {req_is_write, req_addr, req_data}, mq[0]);
    check("rdvalid", softreg_rdvalid_out, m_rdv);
    check("rddata", softreg_rddata_out, m_rdd);
    check("ovf_count", ovf_count, m_ovf);
    check("err_flags", err_flags, m_err);
    rst               = s_rst;
    softreg_read_in   = s_rd;
    softreg_write_in  = s_wr;
    softreg_addr_in   = s_addr;
    softreg_wrdata_in = s_wd;
    req_ready         = s_ready;
    resp_valid        = s_rv;
    resp_data         = s_rdat;
    model_step();
  endtask

  task automatic idle();
    s_rst = 0; s_rd = 0; s_wr = 0; s_rv = 0;
    s_addr = '0; s_wd = '0; s_rdat = '0;
  endtask

  task automatic do_reset();
    idle();
    s_rst = 1;
    cycle();
    cycle();
    s_rst = 0;
    cycle();
  endtask

  initial begin
    bit seen;
    int rp;
    rst = 1; softreg_read_in = 0; softreg_write_in = 0; softreg_addr_in = '0;
    softreg_wrdata_in = '0; req_ready = 0; resp_valid = 0; resp_data = '0;
    s_ready = 1;
    do_reset();
    check("reset_outs", {req_valid, softreg_rdvalid_out, softreg_rddata_out, ovf_count,
                         err_flags}, '0);

    // Single write reaches the downstream port one cycle after the strobe.
    s_wr = 1; s_addr = 32'h10; s_wd = 64'h1234;
    cycle();
    idle();
    cycle();
    check("wr_issue", {req_valid, req_is_write, req_addr, req_data, softreg_rdvalid_out},
          {1'b1, 1'b1, 32'h10, 64'h1234, 1'b0});

    // Read with response three cycles after issue.
    s_rd = 1; s_addr = 32'h20;
    cycle();
    idle();
    cycle();
    check("rd_issue", {req_valid, req_is_write, req_addr}, {1'b1, 1'b0, 32'h20});
    cycle();
    cycle();
    s_rv = 1; s_rdat = 64'hCAFE;
    cycle();
    idle();
    cycle();
    check("rd_resp", {softreg_rdvalid_out, softreg_rddata_out}, {1'b1, 64'hCAFE});
    cycle();
    check("rd_pulse_once", softreg_rdvalid_out, 1'b0);

    // Overflow: 17 writes against a stalled consumer, then drain in order.
    do_reset();
    s_ready = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      s_wr = 1; s_addr = 32'h100 + i; s_wd = {$urandom(), $urandom()};
      cycle();
    end
    idle();
    cycle();
    check("ovf_one", ovf_count, 16'd1);
    s_ready = 1;
    for (int i = 0; i < DEPTH + 3; i++) cycle();
    check("drained", req_valid, 1'b0);

    // Read limit: fifth read held until a response frees a slot.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      s_rd = 1; s_addr = 32'h200 + i;
      cycle();
    end
    idle();
    for (int i = 0; i < 4; i++) cycle();
    check("rd_limit_hold", {req_valid, req_addr}, {1'b0, 32'h204});
    s_rv = 1; s_rdat = 64'h1;
    cycle();
    idle();
    cycle();
    check("rd_limit_release", {req_valid, req_addr}, {1'b1, 32'h204});
    cycle();

    // Timeout: filler data, then the late response is discarded.
    do_reset();
    s_rd = 1; s_addr = 32'h30;
    cycle();
    idle();
    seen = 0;
    for (int i = 0; i < TO + 6; i++) begin
      cycle();
      if (softreg_rdvalid_out && softreg_rddata_out == TD) seen = 1;
    end
    check("timeout_filler", seen, 1'b1);
    s_rv = 1; s_rdat = 64'h5555;
    cycle();
    idle();
    cycle();
    cycle();
    check("late_resp_dropped", {softreg_rdvalid_out, err_flags}, {1'b0, 3'b001});

    // Read and write strobes together: only the write goes through.
    do_reset();
    s_rd = 1; s_wr = 1; s_addr = 32'h40; s_wd = 64'h77;
    cycle();
    idle();
    cycle();
    check("collision_wr", {req_valid, req_is_write, err_flags}, {1'b1, 1'b1, 3'b010});
    cycle();
    check("collision_no_rd", req_valid, 1'b0);

    // Reset with queued and in-flight requests.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      s_rd = (i % 2 == 0); s_wr = (i % 2 == 1); s_addr = 32'h300 + i; s_wd = 64'(i);
      cycle();
    end
    idle();
    s_ready = 0;
    cycle();
    do_reset();
    cycle();
    check("rst_clear", {req_valid, softreg_rdvalid_out, ovf_count, err_flags}, '0);
    s_ready = 1;

    // Randomized traffic with varying response rates.
    for (int seg = 0; seg < 3; seg++) begin
      rp = (seg == 0) ? 40 : (seg == 1) ? 10 : 2;
      for (int i = 0; i < 1500; i++) begin
        s_rst   = ($urandom_range(0, 599) == 0);
        s_rd    = ($urandom_range(0, 2) == 0);
        s_wr    = ($urandom_range(0, 2) == 0);
        s_addr  = $urandom();
        s_wd    = {$urandom(), $urandom()};
        s_ready = ($urandom_range(0, 9) < 7);
        s_rv    = (m_rd_out > 0 || m_dp > 0) ? ($urandom_range(0, 99) < rp)
                                             : ($urandom_range(0, 99) == 0);
        s_rdat  = {$urandom(), $urandom()};
        cycle();
      end
    end
    idle();
    for (int i = 0; i < 5; i++) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
